// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_round_ctrl : iterative AES round sequencer around an external datapath  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_round,
  input  logic [0:127] rk_data,
  output logic [0:127] dp_state,
  output logic         dp_final,
  input  logic [0:127] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam logic [3:0] c_lastRound = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsmState_e;

  fsmState_e    r_fsm;
  fsmState_e    w_fsmNext;
  logic [3:0]   r_roundCnt;
  logic [3:0]   w_roundCntNext;
  logic [0:127] r_state;
  logic [0:127] w_stateNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_roundCnt <= 4'd0;
      r_state    <= 128'h0;
    end else begin
      r_fsm      <= w_fsmNext;
      r_roundCnt <= w_roundCntNext;
      r_state    <= w_stateNext;
    end
  end

  always_comb begin
    w_fsmNext      = r_fsm;
    w_roundCntNext = r_roundCnt;
    w_stateNext    = r_state;
    in_ready       = 1'b0;
    rk_round       = 4'd0;
    dp_final       = 1'b0;
    out_valid      = 1'b0;
    busy           = 1'b1;

    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          // Round-0 AddRoundKey is folded into the load; rk_round is 0 here.
          w_stateNext    = in_data ^ rk_data;
          w_roundCntNext = 4'd1;
          w_fsmNext      = ROUND;
        end
      end
      ROUND: begin
        rk_round    = r_roundCnt;
        w_stateNext = dp_result;
        if (r_roundCnt == c_lastRound) begin
          dp_final  = 1'b1;
          w_fsmNext = DONE;
        end else begin
          w_roundCntNext = r_roundCnt + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsmNext      = IDLE;
          w_roundCntNext = 4'd0;
        end
      end
      default: begin
        w_fsmNext      = IDLE;
        w_roundCntNext = 4'd0;
      end
    endcase
  end

  assign dp_state = r_state;
  assign out_data = r_state;

endmodule
`default_nettype wire
